// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the space invaders game blocks.
package space_invaders_pkg;

    localparam int ALIEN_ID_W   = 3;
    localparam int N_ALIENS_DEF = 8;
    localparam int N_SLOTS_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2,
        ST_COOL  = 2'd3
    } fire_state_e;

endpackage

// File: rtl/alien_fire_scheduler_rr_pick.sv
// Circular first-set search: returns the lowest request index at or after ptr.
module rr_pick
    import space_invaders_pkg::*;
#(
    parameter int N = N_ALIENS_DEF
) (
    input  logic [N-1:0]          req,
    input  logic [ALIEN_ID_W-1:0] ptr,
    output logic                  valid,
    output logic [ALIEN_ID_W-1:0] index
);

    int j;

    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                index = ALIEN_ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/alien_fire_scheduler.sv
// Schedules alien rocket launches: one shot per fire_tick rising edge, round-robin
// over alive aliens, onto the lowest free rocket slot, followed by a cooldown.
module alien_fire_scheduler
    import space_invaders_pkg::*;
#(
    parameter int N_ALIENS     = N_ALIENS_DEF,
    parameter int N_SLOTS      = N_SLOTS_DEF,
    parameter int COOLDOWN_CYC = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             playing,
    input  logic                             fire_tick,
    input  logic [N_ALIENS-1:0]              alive,
    input  logic [N_SLOTS-1:0]               slot_busy,
    output logic [N_SLOTS-1:0]               fire,
    output logic [N_SLOTS*ALIEN_ID_W-1:0]    shooter,
    output logic [7:0]                       shots,
    output fire_state_e                      state_dbg
);

    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CNT_W  = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

    fire_state_e                     state_q, state_d;
    logic                            tick_q;
    logic [ALIEN_ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [N_SLOTS-1:0]              fire_q, fire_d;
    logic [N_SLOTS*ALIEN_ID_W-1:0]   shooter_q, shooter_d;
    logic [7:0]                      shots_q, shots_d;
    logic [SLOT_W-1:0]               slot_sel_q, slot_sel_d;
    logic [ALIEN_ID_W-1:0]           win_q, win_d;

    logic                            tick_edge;
    logic                            pick_valid;
    logic [ALIEN_ID_W-1:0]           pick_idx;
    logic                            free_valid;
    logic [SLOT_W-1:0]               free_idx;

    assign tick_edge = fire_tick & ~tick_q;

    rr_pick #(.N(N_ALIENS)) u_rr_pick (
        .req   (alive),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Downward scan so the last assignment wins with the lowest free slot.
    always_comb begin
        free_valid = 1'b0;
        free_idx   = '0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (!slot_busy[s]) begin
                free_valid = 1'b1;
                free_idx   = SLOT_W'(s);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_q     <= 1'b0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            fire_q     <= '0;
            shooter_q  <= '0;
            shots_q    <= '0;
            slot_sel_q <= '0;
            win_q      <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= fire_tick;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            fire_q     <= fire_d;
            shooter_q  <= shooter_d;
            shots_q    <= shots_d;
            slot_sel_q <= slot_sel_d;
            win_q      <= win_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        fire_d     = '0;
        shooter_d  = shooter_q;
        shots_d    = shots_q;
        slot_sel_d = slot_sel_q;
        win_d      = win_q;

        if (state_q == ST_IDLE) begin
            rr_ptr_d = '0;
        end

        if (!playing) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (tick_edge && pick_valid && free_valid) begin
                        slot_sel_d       = free_idx;
                        win_d            = pick_idx;
                        fire_d[free_idx] = 1'b1;
                        state_d          = ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    shooter_d[int'(slot_sel_q)*ALIEN_ID_W +: ALIEN_ID_W] = win_q;
                    rr_ptr_d = (int'(win_q) == N_ALIENS - 1) ? '0 : win_q + 1'b1;
                    if (shots_q != 8'hFF) begin
                        shots_d = shots_q + 8'd1;
                    end
                    cnt_d   = CNT_W'(COOLDOWN_CYC - 1);
                    state_d = ST_COOL;
                end
                ST_COOL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The launch pulse is registered; playing only masks it so a game stop is immediate.
    always_comb begin
        fire      = fire_q & {N_SLOTS{playing}};
        shooter   = shooter_q;
        shots     = shots_q;
        state_dbg = state_q;
    end

endmodule

// File: doc/alien_fire_scheduler.md
ALIEN_FIRE_SCHEDULER -- requirements
Module: alien_fire_scheduler

Interface
REQ-001 SHALL have parameter N_ALIENS, default 8, number of alien fire requesters.
REQ-002 SHALL have parameter N_SLOTS, default 2, number of shared alien rocket instances.
REQ-003 SHALL have parameter COOLDOWN_CYC, default 4, idle cycles between consecutive shots (minimum 1).
REQ-004 SHALL have port clk  input  1  single clock for all state.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port playing  input  1  game-active level.
REQ-007 SHALL have port fire_tick  input  1  slow divider level; each rising edge is one fire opportunity.
REQ-008 SHALL have port alive  input  N_ALIENS  per-alien alive flags.
REQ-009 SHALL have port slot_busy  input  N_SLOTS  per-slot rocket flying flag.
REQ-010 SHALL have port fire  output  N_SLOTS  one-cycle launch pulse per slot.
REQ-011 SHALL have port shooter  output  N_SLOTS*3  per-slot alien index feeding that rocket's start position mux.
REQ-012 SHALL have port shots  output  8  total shots launched.

Function
REQ-013 SHALL detect fire_tick rising edge via a registered copy (tick_q); edge = fire_tick & ~tick_q.
REQ-014 SHALL implement states IDLE, ARMED, FIRE, COOL.
REQ-015 IDLE: fire=0; rr_ptr held at 0; go to ARMED when playing=1.
REQ-016 ARMED: on tick edge with |alive=1 and at least one slot_busy bit 0, register slot_sel = lowest-index free slot and win = first alive index at or after rr_ptr (circular), then go to FIRE; otherwise stay in ARMED and drop the tick.
REQ-017 FIRE: lasts exactly one cycle; fire[slot_sel]=1, all other fire bits 0; shooter[slot_sel] <= win.
REQ-018 FIRE: rr_ptr <= (win+1) mod N_ALIENS; shots <= shots+1, saturating at 255; then go to COOL with counter = COOLDOWN_CYC-1.
REQ-019 Latency: tick edge sampled in ARMED at cycle k -> fire high during cycle k+1 only.
REQ-020 COOL: decrement counter each cycle; at 0, go to ARMED; tick edges in COOL are dropped, not queued.
REQ-021 shooter entries SHALL hold their last value until the same slot fires again.
REQ-022 playing=0 in any state SHALL force IDLE next cycle; fire is gated by playing, so no pulse occurs in a cycle where playing=0, and shots does not increment.
REQ-023 Alive or slot changes after the ARMED decision SHALL NOT cancel the FIRE cycle; the rocket block ignores fire while its slot is flying.
REQ-024 A tick edge coinciding with the COOL->ARMED transition SHALL be dropped; edges are evaluated only while in ARMED.

Reset
REQ-025 Reset SHALL force state=IDLE, tick_q=0, rr_ptr=0, counter=0, fire=0, shooter all 0, and shots=0, asynchronously; reset mid-FIRE aborts the pulse immediately.

Structure
REQ-026 The shared package space_invaders_pkg SHALL hold the state enum, the ALIEN_ID_W=3 constant and default N_ALIENS/N_SLOTS.
REQ-027 Round-robin selection SHALL live in one sub-module rr_pick (inputs req vector and ptr; outputs valid and index); everything else stays inline.
REQ-028 fire and state SHALL be registered; there SHALL be no combinational path from alive or slot_busy to fire.

Verification
REQ-029 Reset, playing=1, alive=8'hFF, slot_busy=0, first tick edge -> fire=2'b01 one cycle later, shooter[0]=0, shots=1, rr_ptr=1.
REQ-030 alive=8'b1010_0000, rr_ptr=0, three spaced tick edges -> shooters 5, 7, 5 in order (wrap-around).
REQ-031 slot_busy=2'b01, tick edge -> fire=2'b10; slot_busy=2'b11, tick edge -> no fire and shots unchanged.
REQ-032 Two tick edges 2 cycles apart with COOLDOWN_CYC=4 -> exactly one fire pulse; second edge dropped.
REQ-033 playing dropped during FIRE cycle -> fire=0, shots unchanged, IDLE next cycle; alive=0 with tick edge -> no fire.
REQ-034 Reset asserted mid-COOL -> all outputs 0 immediately; shots saturates at 255 after 300 shots.
